// File: rtl/cplx_peak_pkg.sv
// Shared types and default geometry for the complex peak detector.
// The bench's reference model uses res_t from here.
package cplx_peak_pkg;
  localparam int DW     = 16;
  localparam int MAXLEN = 1024;
  localparam int PW     = 2 * DW;
  localparam int IW     = $clog2(MAXLEN);
  localparam int EW     = PW + IW;

  typedef enum logic {ACC, HOLD} state_t;

  typedef struct packed {
    logic [PW-1:0] pwr;
    logic [IW-1:0] idx;
    logic [IW:0]   cnt;
    logic [EW-1:0] energy;
    logic          err;
  } res_t;
endpackage

// File: rtl/cplx_pwr.sv
// Two-stage |x|^2 pipeline: squares at P1, sum at P2.
// Carries the valid, frame-done and sample-index sidebands alongside.
module cplx_pwr #(
  parameter int DW = 16,
  parameter int IW = 10
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            in_vld,
  input  logic            in_done,
  input  logic [IW-1:0]   in_idx,
  input  logic [DW-1:0]   in_i,
  input  logic [DW-1:0]   in_q,
  output logic            out_vld,
  output logic            out_done,
  output logic [IW-1:0]   out_idx,
  output logic [2*DW-1:0] out_pwr
);
  import cplx_peak_pkg::*;

  localparam int STAGES = 2;
  localparam int SW     = 2 * DW;

  logic [STAGES:1]   vld_pipe, done_pipe;
  logic [IW-1:0]     idx_p1;
  logic [SW-1:0]     ii_p1, qq_p1;
  logic signed [SW-1:0] iw, qw;

  // Squares are non-negative and at most 2^(2DW-2), so the PW-bit sum never wraps.
  always_comb begin
    iw = SW'($signed(in_i));
    qw = SW'($signed(in_q));
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      vld_pipe  <= '0;
      done_pipe <= '0;
      idx_p1    <= '0;
      ii_p1     <= '0;
      qq_p1     <= '0;
      out_idx   <= '0;
      out_pwr   <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], in_vld};
      done_pipe <= {done_pipe[STAGES-1:1], in_done};
      idx_p1    <= in_idx;
      ii_p1     <= unsigned'(iw * iw);
      qq_p1     <= unsigned'(qw * qw);
      out_idx   <= idx_p1;
      out_pwr   <= ii_p1 + qq_p1;
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_done = done_pipe[STAGES];
endmodule

// File: rtl/cplx_peak_detect.sv
// Per-frame peak power / peak index / energy tracker with held result record.
// Optional threshold-hit reporting is built when PEAK_THRESH_EN is defined.
module cplx_peak_detect #(
  parameter int DW     = 16,
  parameter int MAXLEN = 1024
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic                             in_en,
  input  logic [DW-1:0]                    in_data_i,
  input  logic [DW-1:0]                    in_data_q,
  input  logic                             in_done,
  input  logic                             res_ack,
`ifdef PEAK_THRESH_EN
  input  logic [2*DW-1:0]                  thresh,
  output logic                             res_hit,
  output logic [$clog2(MAXLEN)-1:0]        res_first,
`endif
  output logic                             busy,
  output logic                             res_valid,
  output logic [2*DW-1:0]                  res_pwr,
  output logic [$clog2(MAXLEN)-1:0]        res_idx,
  output logic [$clog2(MAXLEN):0]          res_cnt,
  output logic [2*DW+$clog2(MAXLEN)-1:0]   res_energy,
  output logic                             res_err
);
  import cplx_peak_pkg::*;

  localparam int LPW = 2 * DW;
  localparam int LIW = $clog2(MAXLEN);
  localparam int LEW = LPW + LIW;
  localparam logic [LIW:0]   CNT_MAX = (LIW+1)'(MAXLEN);
  localparam logic [LIW-1:0] IDX_MAX = LIW'(MAXLEN - 1);

  state_t state, state_nxt;
  logic   ack_acc, load;

  logic           accept, done_acc, drop_now;
  logic [LIW:0]   cnt;
  logic [LIW-1:0] s_idx;
  logic           frame_err, drop_flag;

  logic           p_vld, p_done;
  logic [LIW-1:0] p_idx;
  logic [LPW-1:0] p_pwr;

  logic           have, have_nxt;
  logic [LPW-1:0] cur_max, max_nxt;
  logic [LIW-1:0] cur_idx, idx_nxt;
  logic [LEW-1:0] energy, eng_nxt;
  logic [LEW:0]   eng_sum;

  // Anything arriving while busy belongs to no frame; it is dropped and flagged.
  assign accept   = in_en && !busy;
  assign done_acc = in_done && !busy;
  assign drop_now = busy && (in_en || in_done);
  assign s_idx    = (cnt >= CNT_MAX) ? IDX_MAX : cnt[LIW-1:0];

  cplx_pwr #(.DW(DW), .IW(LIW)) u_pwr (
    .clk      (clk),
    .rstb     (rstb),
    .in_vld   (accept),
    .in_done  (done_acc),
    .in_idx   (s_idx),
    .in_i     (in_data_i),
    .in_q     (in_data_q),
    .out_vld  (p_vld),
    .out_done (p_done),
    .out_idx  (p_idx),
    .out_pwr  (p_pwr)
  );

  always_ff @(posedge clk) begin
    if (!rstb) state <= ACC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:  if (p_done)  state_nxt = HOLD;
      HOLD: if (ack_acc) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    res_valid = (state == HOLD);
    ack_acc   = res_valid && res_ack;
    load      = (state == ACC) && p_done;
  end

  // Next accumulator values include the P2 sample, so a done aligned with the
  // last sample captures that sample in the result.
  always_comb begin
    max_nxt  = cur_max;
    idx_nxt  = cur_idx;
    have_nxt = have;
    eng_nxt  = energy;
    eng_sum  = {1'b0, energy} + (LEW+1)'(p_pwr);
    if (p_vld) begin
      if (!have || p_pwr > cur_max) begin
        max_nxt = p_pwr;
        idx_nxt = p_idx;
      end
      have_nxt = 1'b1;
      eng_nxt  = eng_sum[LEW] ? '1 : eng_sum[LEW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      busy       <= 1'b0;
      cnt        <= '0;
      frame_err  <= 1'b0;
      drop_flag  <= 1'b0;
      have       <= 1'b0;
      cur_max    <= '0;
      cur_idx    <= '0;
      energy     <= '0;
      res_pwr    <= '0;
      res_idx    <= '0;
      res_cnt    <= '0;
      res_energy <= '0;
      res_err    <= 1'b0;
    end else begin
      if (done_acc)     busy <= 1'b1;
      else if (ack_acc) busy <= 1'b0;

      if (ack_acc) begin
        cnt       <= '0;
        frame_err <= drop_flag | drop_now;
        drop_flag <= 1'b0;
        have      <= 1'b0;
        cur_max   <= '0;
        cur_idx   <= '0;
        energy    <= '0;
      end else begin
        if (accept && cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (accept && cnt == CNT_MAX) frame_err <= 1'b1;
        drop_flag <= drop_flag | drop_now;
        have      <= have_nxt;
        cur_max   <= max_nxt;
        cur_idx   <= idx_nxt;
        energy    <= eng_nxt;
      end

      if (load) begin
        res_pwr    <= max_nxt;
        res_idx    <= idx_nxt;
        res_cnt    <= cnt;
        res_energy <= eng_nxt;
        res_err    <= frame_err;
      end
    end
  end

`ifdef PEAK_THRESH_EN
  logic [LPW-1:0] thr_q;
  logic           hit, hit_nxt;
  logic [LIW-1:0] first, first_nxt;

  always_comb begin
    hit_nxt   = hit;
    first_nxt = first;
    if (p_vld && !hit && p_pwr >= thr_q) begin
      hit_nxt   = 1'b1;
      first_nxt = p_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      thr_q     <= '0;
      hit       <= 1'b0;
      first     <= '0;
      res_hit   <= 1'b0;
      res_first <= '0;
    end else begin
      if (accept && cnt == '0) thr_q <= thresh;
      if (ack_acc) begin
        hit   <= 1'b0;
        first <= '0;
      end else begin
        hit   <= hit_nxt;
        first <= first_nxt;
      end
      if (load) begin
        res_hit   <= hit_nxt;
        res_first <= first_nxt;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cplx_peak_detect.sv
// Scoreboard bench for cplx_peak_detect: a frame model pushes expected records,
// which are popped and compared when the DUT presents res_valid.
module tb_cplx_peak_detect;
  import cplx_peak_pkg::*;

  logic          clk = 1'b0;
  logic          rstb, in_en, in_done, res_ack;
  logic [DW-1:0] in_data_i, in_data_q;
  logic          busy, res_valid, res_err;
  logic [PW-1:0] res_pwr;
  logic [IW-1:0] res_idx;
  logic [IW:0]   res_cnt;
  logic [EW-1:0] res_energy;
`ifdef PEAK_THRESH_EN
  logic [PW-1:0] thresh;
  logic          res_hit;
  logic [IW-1:0] res_first;
  bit            hit_q[$];
  int            first_q[$];
`endif

  int     n_vec = 0;
  int     n_err = 0;
  res_t   exp_q[$];
  int     si[$], sq[$];
  longint thr_m = 0;
  res_t   last_r;

  cplx_peak_detect #(.DW(DW), .MAXLEN(MAXLEN)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .in_en      (in_en),
    .in_data_i  (in_data_i),
    .in_data_q  (in_data_q),
    .in_done    (in_done),
    .res_ack    (res_ack),
`ifdef PEAK_THRESH_EN
    .thresh     (thresh),
    .res_hit    (res_hit),
    .res_first  (res_first),
`endif
    .busy       (busy),
    .res_valid  (res_valid),
    .res_pwr    (res_pwr),
    .res_idx    (res_idx),
    .res_cnt    (res_cnt),
    .res_energy (res_energy),
    .res_err    (res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_model(input bit extra);
    res_t   r;
    longint p, mx, e, emax;
    int     n, idx, first;
    bit     hit;
    n = si.size(); r = '0; mx = 0; e = 0; hit = 0; first = 0;
    emax = (longint'(1) << EW) - 1;
    for (int k = 0; k < n; k++) begin
      p   = longint'(si[k]) * si[k] + longint'(sq[k]) * sq[k];
      idx = (k < MAXLEN) ? k : MAXLEN - 1;
      if (k == 0 || p > mx) begin mx = p; r.idx = IW'(idx); end
      e = (e + p > emax) ? emax : e + p;
      if (!hit && p >= thr_m) begin hit = 1; first = idx; end
    end
    r.pwr    = PW'(mx);
    r.cnt    = (IW+1)'((n > MAXLEN) ? MAXLEN : n);
    r.energy = EW'(e);
    r.err    = (n > MAXLEN) || extra;
    exp_q.push_back(r);
`ifdef PEAK_THRESH_EN
    hit_q.push_back(hit);
    first_q.push_back(first);
`endif
  endtask

  task automatic drive_frame();
    int n;
    n = si.size();
    if (n == 0) begin
      @(posedge clk); #1 in_done = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        @(posedge clk); #1;
        in_en     = 1'b1;
        in_data_i = DW'(si[k]);
        in_data_q = DW'(sq[k]);
        in_done   = (k == n - 1);
      end
    end
    @(posedge clk); #1;
    in_en = 1'b0; in_done = 1'b0;
  endtask

  task automatic wait_result(output res_t e);
    int t;
    t = 0; e = '0;
    @(negedge clk);
    while (!res_valid && t < 50) begin @(negedge clk); t++; end
    chk("res_valid_seen", res_valid, 1);
    chk("sb_not_empty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("res_pwr", res_pwr, e.pwr);
    chk("res_idx", res_idx, e.idx);
    chk("res_cnt", res_cnt, e.cnt);
    chk("res_energy", res_energy, e.energy);
    chk("res_err", res_err, e.err);
    chk("busy_hold", busy, 1);
`ifdef PEAK_THRESH_EN
    if (hit_q.size() > 0) begin
      chk("res_hit", res_hit, hit_q.pop_front());
      chk("res_first", res_first, first_q.pop_front());
    end
`endif
  endtask

  task automatic do_ack();
    @(posedge clk); #1 res_ack = 1'b1;
    @(posedge clk); #1 res_ack = 1'b0;
    @(negedge clk);
    chk("valid_after_ack", res_valid, 0);
    chk("busy_after_ack", busy, 0);
  endtask

  task automatic run_frame(input bit extra);
    res_t e;
    push_model(extra);
    drive_frame();
    wait_result(e);
    do_ack();
  endtask

  task automatic add(input int i, input int q);
    si.push_back(i); sq.push_back(q);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pwr"}, res_pwr, 0);
    chk({tag, "_idx"}, res_idx, 0);
    chk({tag, "_cnt"}, res_cnt, 0);
    chk({tag, "_energy"}, res_energy, 0);
    chk({tag, "_err"}, res_err, 0);
  endtask

  initial begin
    logic [15:0] v;
    res_t e;
    rstb = 1'b0; in_en = 1'b0; in_done = 1'b0; res_ack = 1'b0;
    in_data_i = '0; in_data_q = '0;
`ifdef PEAK_THRESH_EN
    thresh = '1; thr_m = (longint'(1) << PW) - 1;
`endif
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    @(negedge clk);
    check_zero("reset");

    // basic frame with latency check; (-5,0) ties (3,4) and must not win
    si.delete(); sq.delete();
    add(3, 4); add(0, 0); add(-5, 0); add(1, 1);
    push_model(0);
    drive_frame();
    @(negedge clk);
    chk("busy_at_done+1", busy, 1);
    chk("valid_at_done+1", res_valid, 0);
    @(negedge clk);
    chk("valid_at_done+2", res_valid, 0);
    wait_result(e);
    do_ack();

    // reset mid-frame discards partial frame and the previous result
    @(posedge clk); #1 in_en = 1'b1; in_data_i = 16'd100; in_data_q = 16'd7;
    @(posedge clk); #1 in_data_i = 16'd9;
    @(posedge clk); #1 in_en = 1'b0; rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    si.delete(); sq.delete();
    add(2, 2); add(-1, 7); add(0, 3); add(6, -6);
    run_frame(0);

    // extreme negative sample must not wrap
    si.delete(); sq.delete();
    add(-32768, -32768);
    run_frame(0);

    // empty frame
    si.delete(); sq.delete();
    run_frame(0);

    // backpressure: result frozen, samples dropped, err on next frame
    si.delete(); sq.delete();
    add(7, 1); add(2, 2);
    push_model(0);
    drive_frame();
    wait_result(last_r);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      in_en = (c < 3); in_data_i = 16'd50; in_data_q = 16'd50;
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_busy", busy, 1);
      chk("bp_pwr_frozen", res_pwr, last_r.pwr);
      chk("bp_cnt_frozen", res_cnt, last_r.cnt);
    end
    do_ack();
    si.delete(); sq.delete();
    add(4, 0); add(0, 9);
    run_frame(1);

    // ack while idle is ignored; following frame is clean
    @(posedge clk); #1 res_ack = 1'b1;
    @(posedge clk); #1 res_ack = 1'b0;
    si.delete(); sq.delete();
    add(1, 2);
    run_frame(0);

    // overflow: MAXLEN+2 samples
    si.delete(); sq.delete();
    for (int k = 0; k < MAXLEN + 2; k++) begin
      v = 16'($urandom); si.push_back(int'($signed(v)));
      v = 16'($urandom); sq.push_back(int'($signed(v)));
    end
    run_frame(0);

    // short random frames
    for (int f = 0; f < 4; f++) begin
      si.delete(); sq.delete();
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
        v = 16'($urandom); si.push_back(int'($signed(v)));
        v = 16'($urandom); sq.push_back(int'($signed(v)));
      end
      run_frame(0);
    end

`ifdef PEAK_THRESH_EN
    thresh = 32'd20; thr_m = 20;
    si.delete(); sq.delete();
    add(1, 1); add(3, 4); add(5, 0);
    run_frame(0);
    thresh = 32'd100; thr_m = 100;
    run_frame(0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
